hamming_tx_serial: RTL and testbench

Transmit end of the Hamming SECDED (8,4) link. The block accepts a 4-bit word through a valid/ready handshake and encodes it into the same 8-bit codeword layout the receive-side decoder expects. It then shifts the codeword out on one serial line as a framed, UART-style bit stream. It sits between the switch/input logic and the physical link that feeds the receive board's `palabra_rx` path.

---
 rtl/hamming_tx_serial_if.sv | 23 ++
 rtl/hamming_tx_serial.sv | 87 ++++++++
 tb/tb_hamming_tx_serial.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hamming_tx_serial_if.sv
// hamming_tx_serial_if: word handshake, codeword display and serial line bundle (HAMMING_TX_ERR_INJECT_EN adds inj_en/inj_pos)
interface hamming_tx_serial_if;
   logic [3:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [7:0] codeword;
   logic       tx_serial;
   logic       tx_busy;
   logic       frame_done;
`ifdef HAMMING_TX_ERR_INJECT_EN
   logic       inj_en;
   logic [2:0] inj_pos;
   modport master(output data_in, data_valid, inj_en, inj_pos,
                  input data_ready, codeword, tx_serial, tx_busy, frame_done);
   modport slave(input data_in, data_valid, inj_en, inj_pos,
                 output data_ready, codeword, tx_serial, tx_busy, frame_done);
`else
   modport master(output data_in, data_valid,
                  input data_ready, codeword, tx_serial, tx_busy, frame_done);
   modport slave(input data_in, data_valid,
                 output data_ready, codeword, tx_serial, tx_busy, frame_done);
`endif
endinterface

// File: rtl/hamming_tx_serial.sv
// hamming_tx_serial: SECDED (8,4) encoder + UART-style serial framer; ports clk, rst (async high), bus (slave); HAMMING_TX_ERR_INJECT_EN enables bit-error injection
module hamming_tx_serial #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic             clk,
   input logic             rst,
   hamming_tx_serial_if.slave bus
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d, cw_q, cw_d, enc, inj_mask;
   logic          tx_q, tx_d, last;
   logic [3:0]    d;
   assign d = bus.data_in;
   assign enc[7:1] = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
   assign enc[0] = ^enc[7:1];
`ifdef HAMMING_TX_ERR_INJECT_EN
   // only the line copy is corrupted; the display keeps the clean codeword
   assign inj_mask = bus.inj_en ? 8'b1 << bus.inj_pos : 8'h00;
`else
   assign inj_mask = 8'h00;
`endif
   assign last = baud_q == LAST;
   assign bus.data_ready = state_q == IDLE;
   assign bus.tx_busy = state_q != IDLE;
   assign bus.frame_done = state_q == STOP && last;
   assign bus.codeword = cw_q;
   assign bus.tx_serial = tx_q;
   always_comb begin
      state_d = state_q;
      baud_d = baud_q;
      bit_d = bit_q;
      shift_d = shift_q;
      cw_d = cw_q;
      tx_d = tx_q;
      if (state_q == IDLE) begin
         if (bus.data_valid) begin
            state_d = START;
            baud_d = '0;
            bit_d = 3'd0;
            cw_d = enc;
            shift_d = enc ^ inj_mask;
            tx_d = 1'b0;
         end
      end else if (!last) begin
         baud_d = baud_q + 1'b1;
      end else begin
         baud_d = '0;
         // tx is loaded one bit ahead from the LSB of the shifter, so the line is always a flop output
         case (state_q)
            START: begin
               state_d = DATA;
               tx_d = shift_q[0];
               shift_d = shift_q >> 1;
            end
            DATA: begin
               bit_d = bit_q + 3'd1;
               state_d = bit_q == 3'd7 ? STOP : DATA;
               tx_d = bit_q == 3'd7 ? 1'b1 : shift_q[0];
               shift_d = shift_q >> 1;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q <= '0;
         bit_q <= 3'd0;
         shift_q <= 8'h00;
         cw_q <= 8'h00;
         tx_q <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q <= baud_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         cw_q <= cw_d;
         tx_q <= tx_d;
      end
   end
endmodule

// File: tb/tb_hamming_tx_serial.sv
// tb_hamming_tx_serial: directed self-checking bench for hamming_tx_serial with N=4
module tb_hamming_tx_serial;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   logic [9:0] bits;
   int busy, done;
   logic [7:0] exp_cw [16] = '{8'h00, 8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66, 8'h69,
                               8'h96, 8'h99, 8'hA5, 8'hAA, 8'hC3, 8'hCC, 8'hF0, 8'hFF};
   hamming_tx_serial_if bus();
   hamming_tx_serial #(.CLKS_PER_BIT(N)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // independent receive-side decoder: returns {error_seen, corrected word}
   function automatic logic [4:0] dec(input logic [7:0] c);
      logic [2:0] s;
      logic p;
      logic [7:0] f;
      s[0] = c[1] ^ c[3] ^ c[5] ^ c[7];
      s[1] = c[2] ^ c[3] ^ c[6] ^ c[7];
      s[2] = c[4] ^ c[5] ^ c[6] ^ c[7];
      p = ^c;
      f = c ^ (s != 3'd0 ? 8'b1 << s : (p ? 8'h01 : 8'h00));
      return {s != 3'd0 || p, f[7], f[6], f[5], f[3]};
   endfunction
   // called right after the transfer edge; watches one full 10*N cycle frame
   task automatic rx(input bit hold, input logic [3:0] nd, output logic [9:0] b, output int nb, output int nd_cnt);
      nb = 0;
      nd_cnt = 0;
      b = '0;
      for (int c = 0; c < 10 * N; c++) begin
         @(negedge clk);
         if (c == 0) begin
            if (!hold) bus.data_valid = 1'b0;
            chk("start_first_cycle", bus.tx_serial, 1'b0);
         end
         if (c == 3 * N) bus.data_in = nd;
         if (bus.tx_busy) nb++;
         if (bus.frame_done) nd_cnt++;
         if (c % N == N / 2) b[c / N] = bus.tx_serial;
      end
   endtask
   task automatic send(input logic [3:0] d, input bit hold, output logic [9:0] b, output int nb, output int nd_cnt);
      @(negedge clk);
      bus.data_in = d;
      bus.data_valid = 1'b1;
      chk("ready_before_send", bus.data_ready, 1'b1);
      @(posedge clk);
      rx(hold, d, b, nb, nd_cnt);
   endtask
   initial begin
      bus.data_in = 4'hA;
      bus.data_valid = 1'b1;
`ifdef HAMMING_TX_ERR_INJECT_EN
      bus.inj_en = 1'b0;
      bus.inj_pos = 3'd0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_tx", bus.tx_serial, 1'b1);
      chk("rst_busy", bus.tx_busy, 1'b0);
      chk("rst_ready", bus.data_ready, 1'b1);
      chk("rst_done", bus.frame_done, 1'b0);
      chk("rst_cw", bus.codeword, 8'h00);
      bus.data_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("no_frame_after_rst", bus.tx_busy, 1'b0);
      send(4'b1010, 1'b0, bits, busy, done);
      chk("a_cw", bus.codeword, 8'hA5);
      chk("a_bits", bits, 10'b11_0100_1010);
      chk("a_busy_cycles", busy, 40);
      chk("a_done_pulses", done, 1);
      @(negedge clk);
      chk("a_ready_after", bus.data_ready, 1'b1);
      for (int i = 0; i < 16; i++) begin
         send(4'(i), 1'b0, bits, busy, done);
         chk("sweep_cw", bus.codeword, exp_cw[i]);
         chk("sweep_line", bits[8:1], exp_cw[i]);
         chk("sweep_framing", {bits[9], bits[0]}, 2'b10);
         chk("sweep_decode", dec(bits[8:1]), {1'b0, 4'(i)});
      end
      send(4'b1010, 1'b1, bits, busy, done);
      chk("b2b_first", bits, {1'b1, 8'hA5, 1'b0});
      chk("b2b_first_cw", bus.codeword, 8'hA5);
      bus.data_in = 4'b0101;
      @(negedge clk);
      chk("b2b_gap_tx", bus.tx_serial, 1'b1);
      chk("b2b_gap_ready", bus.data_ready, 1'b1);
      @(posedge clk);
      rx(1'b0, 4'b1111, bits, busy, done);
      chk("b2b_second", bits, {1'b1, 8'h5A, 1'b0});
      chk("b2b_second_cw", bus.codeword, 8'h5A);
      chk("b2b_second_done", done, 1);
      @(negedge clk);
      bus.data_in = 4'b1010;
      bus.data_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.data_valid = 1'b0;
      repeat (4 * N) @(negedge clk);
      chk("mid_bit3_low", bus.tx_serial, 1'b0);
      #2 rst = 1'b1;
      bus.data_in = 4'hF;
      bus.data_valid = 1'b1;
      #1;
      chk("abort_tx", bus.tx_serial, 1'b1);
      chk("abort_busy", bus.tx_busy, 1'b0);
      done = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.frame_done) done++;
      end
      chk("abort_no_done", done, 0);
      chk("abort_no_frame", bus.tx_busy, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      rx(1'b0, 4'h0, bits, busy, done);
      chk("after_abort", bits, {1'b1, 8'hFF, 1'b0});
      chk("after_abort_cw", bus.codeword, 8'hFF);
`ifdef HAMMING_TX_ERR_INJECT_EN
      bus.inj_en = 1'b1;
      bus.inj_pos = 3'd3;
      send(4'b1010, 1'b0, bits, busy, done);
      chk("inj3_line", bits[8:1], 8'hAD);
      chk("inj3_cw", bus.codeword, 8'hA5);
      chk("inj3_dec", dec(bits[8:1]), 5'b1_1010);
      bus.inj_pos = 3'd0;
      send(4'b1010, 1'b0, bits, busy, done);
      chk("inj0_line", bits[8:1], 8'hA4);
      bus.inj_en = 1'b0;
      send(4'b1010, 1'b0, bits, busy, done);
      chk("inj_off_line", bits[8:1], 8'hA5);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
